// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the 16-bit multi-cycle processor: sequences fetch, decode,
// execute, memory and write-back, and keeps saturating debug counters.
module multicycle_control_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [6:0]       input_opcode,
  input  logic             input_ALU_zero,
  output logic             output_PC_PCWrite,
  output logic             output_IR_write,
  output logic             output_IorD,
  output logic             output_mem_write,
  output logic             output_reg_write,
  output logic             output_MemToReg,
  output logic             output_ALUSrcA,
  output logic [1:0]       output_ALUSrcB,
  output logic [2:0]       output_ALUOp,
  output logic [1:0]       output_PCSource,
  output logic [3:0]       output_state,
  output logic             output_halted,
  output logic             output_illegal,
  output logic [CNT_W-1:0] output_instr_count,
  output logic [CNT_W-1:0] output_cycle_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WB    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_RTYPE_WB  = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_HALT      = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_e;

  localparam logic [6:0] OP_ADD  = 7'h00;
  localparam logic [6:0] OP_SUB  = 7'h01;
  localparam logic [6:0] OP_AND  = 7'h02;
  localparam logic [6:0] OP_OR   = 7'h03;
  localparam logic [6:0] OP_ADDI = 7'h10;
  localparam logic [6:0] OP_LW   = 7'h20;
  localparam logic [6:0] OP_SW   = 7'h21;
  localparam logic [6:0] OP_BEQ  = 7'h30;
  localparam logic [6:0] OP_BNE  = 7'h31;
  localparam logic [6:0] OP_JUMP = 7'h40;
  localparam logic [6:0] OP_HALT = 7'h7F;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  localparam logic [1:0] SRCB_REGB = 2'd0;
  localparam logic [1:0] SRCB_ONE  = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_IMM    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  state_e           out_state;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_FETCH;
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Next-state logic; the opcode is stable from DECODE onward.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (input_opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_EXEC_R;
          OP_ADDI:                       state_d = S_EXEC_I;
          OP_LW, OP_SW:                  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                state_d = S_BRANCH;
          OP_JUMP:                       state_d = S_JUMP;
          OP_HALT:                       state_d = S_HALT;
          default:                       state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:    state_d = S_RTYPE_WB;
      S_EXEC_I:    state_d = S_RTYPE_WB;
      S_MEM_ADDR:  state_d = (input_opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = S_FETCH;
      S_RTYPE_WB:  state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      S_ILLEGAL:   state_d = S_ILLEGAL;
      default:     state_d = S_ILLEGAL;
    endcase
  end

  // Saturating debug counters.
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    if ((state_q == S_FETCH) && (instr_cnt_q != CNT_MAX)) begin
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end
    if ((state_q != S_HALT) && (state_q != S_ILLEGAL) && (cycle_cnt_q != CNT_MAX)) begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    end
  end

  // While in reset the outputs present FETCH selects with every write strobe held low.
  assign out_state = RST_N ? state_q : S_FETCH;

  // Moore output decode; only the BRANCH PC strobe looks at the zero flag.
  always_comb begin
    output_PC_PCWrite = 1'b0;
    output_IR_write   = 1'b0;
    output_IorD       = 1'b0;
    output_mem_write  = 1'b0;
    output_reg_write  = 1'b0;
    output_MemToReg   = 1'b0;
    output_ALUSrcA    = 1'b0;
    output_ALUSrcB    = SRCB_REGB;
    output_ALUOp      = ALU_ADD;
    output_PCSource   = PCSRC_ALU;
    output_halted     = 1'b0;
    output_illegal    = 1'b0;
    unique case (out_state)
      S_FETCH: begin
        output_IR_write   = 1'b1;
        output_ALUSrcB    = SRCB_ONE;
        output_PC_PCWrite = 1'b1;
      end
      S_DECODE: output_ALUSrcB = SRCB_IMM;
      S_EXEC_R: begin
        output_ALUSrcA = 1'b1;
        output_ALUOp   = 3'({1'b0, input_opcode[1:0]});
      end
      S_EXEC_I, S_MEM_ADDR: begin
        output_ALUSrcA = 1'b1;
        output_ALUSrcB = SRCB_IMM;
      end
      S_MEM_READ: output_IorD = 1'b1;
      S_MEM_WB: begin
        output_reg_write = 1'b1;
        output_MemToReg  = 1'b1;
      end
      S_MEM_WRITE: begin
        output_IorD      = 1'b1;
        output_mem_write = 1'b1;
      end
      S_RTYPE_WB: output_reg_write = 1'b1;
      S_BRANCH: begin
        output_ALUSrcA    = 1'b1;
        output_ALUOp      = ALU_SUB;
        output_PCSource   = PCSRC_ALUOUT;
        output_PC_PCWrite = (input_opcode == OP_BNE) ? !input_ALU_zero : input_ALU_zero;
      end
      S_JUMP: begin
        output_PCSource   = PCSRC_IMM;
        output_PC_PCWrite = 1'b1;
      end
      S_HALT:    output_halted  = 1'b1;
      S_ILLEGAL: output_illegal = 1'b1;
      default:   output_illegal = 1'b1;
    endcase
    if (!RST_N) begin
      output_PC_PCWrite = 1'b0;
      output_IR_write   = 1'b0;
      output_mem_write  = 1'b0;
      output_reg_write  = 1'b0;
    end
  end

  assign output_state       = 4'(out_state);
  assign output_instr_count = instr_cnt_q;
  assign output_cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: the driver pushes hand-derived expected outputs per cycle,
// a negedge monitor pops and compares them against both DUT instances.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [3:0]  st;
    logic        pcw;
    logic        irw;
    logic        iord;
    logic        memw;
    logic        regw;
    logic        m2r;
    logic        srca;
    logic [1:0]  srcb;
    logic [2:0]  aluop;
    logic [1:0]  pcsrc;
    logic        halted;
    logic        illegal;
    logic [15:0] ic;
    logic [15:0] cc;
  } exp_t;

  logic        CLK;
  logic        rst_n, zero;
  logic [6:0]  opcode;
  logic        pcw, irw, iord, memw, regw, m2r, srca, halted, illegal;
  logic [1:0]  srcb, pcsrc;
  logic [2:0]  aluop;
  logic [3:0]  st;
  logic [15:0] ic, cc;

  logic        rst2_n;
  logic [6:0]  opcode2;
  logic        pcw2, irw2, iord2, memw2, regw2, m2r2, srca2, halted2, illegal2;
  logic [1:0]  srcb2, pcsrc2;
  logic [2:0]  aluop2;
  logic [3:0]  st2;
  logic [3:0]  ic2, cc2;

  exp_t        q1[$];
  logic [11:0] q2[$];
  exp_t        e1, g1;
  logic [11:0] e2, g2;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] exp_ic, exp_cc;
  logic [3:0]  exp_ic2, exp_cc2;

  multicycle_control_unit #(.CNT_W(16)) dut (
    .CLK(CLK), .RST_N(rst_n), .input_opcode(opcode), .input_ALU_zero(zero),
    .output_PC_PCWrite(pcw), .output_IR_write(irw), .output_IorD(iord),
    .output_mem_write(memw), .output_reg_write(regw), .output_MemToReg(m2r),
    .output_ALUSrcA(srca), .output_ALUSrcB(srcb), .output_ALUOp(aluop),
    .output_PCSource(pcsrc), .output_state(st), .output_halted(halted),
    .output_illegal(illegal), .output_instr_count(ic), .output_cycle_count(cc)
  );

  multicycle_control_unit #(.CNT_W(4)) dut_sat (
    .CLK(CLK), .RST_N(rst2_n), .input_opcode(opcode2), .input_ALU_zero(1'b0),
    .output_PC_PCWrite(pcw2), .output_IR_write(irw2), .output_IorD(iord2),
    .output_mem_write(memw2), .output_reg_write(regw2), .output_MemToReg(m2r2),
    .output_ALUSrcA(srca2), .output_ALUSrcB(srcb2), .output_ALUOp(aluop2),
    .output_PCSource(pcsrc2), .output_state(st2), .output_halted(halted2),
    .output_illegal(illegal2), .output_instr_count(ic2), .output_cycle_count(cc2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected control word for a state, taken from the state table.
  function automatic exp_t expect_of(input logic [3:0] s, input logic [6:0] op,
                                     input logic z, input logic rn);
    exp_t e;
    e = '0;
    e.st = rn ? s : 4'd0;
    case (e.st)
      4'd0:  begin e.irw = 1'b1; e.srcb = 2'd1; e.pcw = 1'b1; end
      4'd1:  e.srcb = 2'd2;
      4'd2:  begin e.srca = 1'b1; e.aluop = (op == 7'h01) ? 3'd1 : (op == 7'h02) ? 3'd2 :
                                             (op == 7'h03) ? 3'd3 : 3'd0; end
      4'd3:  begin e.srca = 1'b1; e.srcb = 2'd2; end
      4'd4:  begin e.srca = 1'b1; e.srcb = 2'd2; end
      4'd5:  e.iord = 1'b1;
      4'd6:  begin e.regw = 1'b1; e.m2r = 1'b1; end
      4'd7:  begin e.iord = 1'b1; e.memw = 1'b1; end
      4'd8:  e.regw = 1'b1;
      4'd9:  begin e.srca = 1'b1; e.aluop = 3'd1; e.pcsrc = 2'd1;
                   e.pcw = (op == 7'h30) ? z : !z; end
      4'd10: begin e.pcsrc = 2'd2; e.pcw = 1'b1; end
      4'd11: e.halted = 1'b1;
      4'd12: e.illegal = 1'b1;
      default: e.illegal = 1'b1;
    endcase
    if (!rn) begin
      e.pcw = 1'b0;
      e.irw = 1'b0;
    end
    return e;
  endfunction

  // One cycle on the main DUT: drive inputs, queue the expected outputs.
  task automatic step(input logic [3:0] s, input logic [6:0] op, input logic z, input logic rn);
    exp_t e;
    @(posedge CLK); #1;
    rst_n = rn; opcode = op; zero = z;
    e = expect_of(s, op, z, rn);
    e.ic = exp_ic;
    e.cc = exp_cc;
    q1.push_back(e);
    if (!rn) begin
      exp_ic = '0;
      exp_cc = '0;
    end else begin
      if (s == 4'd0 && exp_ic != 16'hFFFF) exp_ic = exp_ic + 16'd1;
      if (s != 4'd11 && s != 4'd12 && exp_cc != 16'hFFFF) exp_cc = exp_cc + 16'd1;
    end
  endtask

  // Run one instruction given its state sequence, first state in the low nibble.
  task automatic run(input logic [6:0] op, input logic z, input int n, input logic [19:0] seq);
    for (int i = 0; i < n; i++) step(seq[i*4 +: 4], op, z, 1'b1);
  endtask

  task automatic step2(input logic [3:0] s, input logic rn);
    @(posedge CLK); #1;
    rst2_n = rn;
    q2.push_back({rn ? s : 4'd0, exp_ic2, exp_cc2});
    if (!rn) begin
      exp_ic2 = '0;
      exp_cc2 = '0;
    end else begin
      if (s == 4'd0 && exp_ic2 != 4'hF) exp_ic2 = exp_ic2 + 4'd1;
      if (exp_cc2 != 4'hF) exp_cc2 = exp_cc2 + 4'd1;
    end
  endtask

  // Monitor: compare every queued expectation against what the DUTs present.
  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      g1 = {st, pcw, irw, iord, memw, regw, m2r, srca, srcb, aluop, pcsrc, halted, illegal, ic, cc};
      checks++;
      if (g1 !== e1) begin
        failures++;
        $display("FAIL ctrl cyc%0d exp_state=%0d got=%h expected=%h", cyc, e1.st, g1, e1);
      end
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      g2 = {st2, ic2, cc2};
      checks++;
      if (g2 !== e2) begin
        failures++;
        $display("FAIL sat cyc%0d state/ic/cc got=%h expected=%h", cyc, g2, e2);
      end
    end
  end

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; zero = 1'b0;
    opcode = 7'h00; opcode2 = 7'h40;
    exp_ic = '0; exp_cc = '0; exp_ic2 = '0; exp_cc2 = '0;
    repeat (2) @(posedge CLK);

    step(4'd0, 7'h00, 1'b0, 1'b0);             // reset held: FETCH selects, strobes low
    run(7'h00, 1'b0, 4, 20'h08210);            // ADD
    run(7'h01, 1'b0, 4, 20'h08210);            // SUB
    run(7'h03, 1'b0, 4, 20'h08210);            // OR
    run(7'h10, 1'b0, 4, 20'h08310);            // ADDI
    run(7'h20, 1'b0, 5, 20'h65410);            // LW
    run(7'h21, 1'b0, 4, 20'h07410);            // SW
    run(7'h30, 1'b1, 3, 20'h00910);            // BEQ taken
    run(7'h30, 1'b0, 3, 20'h00910);            // BEQ not taken
    run(7'h31, 1'b1, 3, 20'h00910);            // BNE not taken
    run(7'h31, 1'b0, 3, 20'h00910);            // BNE taken
    run(7'h40, 1'b0, 3, 20'h00A10);            // JUMP

    // Reset during EXEC_R: no write-back, restart at FETCH
    run(7'h00, 1'b0, 2, 20'h00010);
    step(4'd2, 7'h00, 1'b0, 1'b0);
    run(7'h02, 1'b0, 4, 20'h08210);            // AND after reset

    // Illegal opcode locks up with frozen cycle count
    run(7'h55, 1'b0, 2, 20'h00010);
    for (int i = 0; i < 5; i++) step(4'd12, 7'h55, 1'b0, 1'b1);
    step(4'd12, 7'h55, 1'b0, 1'b0);
    step(4'd0, 7'h55, 1'b0, 1'b1);
    step(4'd1, 7'h7F, 1'b0, 1'b1);

    // HALT held for 20 cycles, then reset
    for (int i = 0; i < 20; i++) step(4'd11, 7'h7F, 1'b1, 1'b1);
    step(4'd11, 7'h7F, 1'b0, 1'b0);
    step(4'd0, 7'h7F, 1'b0, 1'b1);

    // Narrow counters saturate at 15 after 20 JUMP instructions
    step2(4'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step2(4'd0, 1'b1);
      step2(4'd1, 1'b1);
      step2(4'd10, 1'b1);
    end
    step2(4'd0, 1'b1);

    @(posedge CLK);
    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style control FSM for the 16-bit multi-cycle processor.
- Sits directly downstream of the fetch/memory datapath. It consumes the 7-bit opcode latched in the instruction register and the ALU zero flag.
- It produces every write strobe and mux select that sequences fetch, decode, execute, memory and write-back.
- It also keeps retired-instruction and cycle counters for debug.

Parameters:
- CNT_W, 16, width of the instruction and cycle counters.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  synchronous active-low reset.
- input_opcode  input  7  opcode field from the instruction register.
- input_ALU_zero  input  1  combinational ALU result==0 flag for the current cycle.
- output_PC_PCWrite  output  1  PC load strobe.
- output_IR_write  output  1  instruction register load strobe.
- output_IorD  output  1  memory address select: 0=PC, 1=ALUOut.
- output_mem_write  output  1  memory write strobe.
- output_reg_write  output  1  register file write strobe, destination RegD.
- output_MemToReg  output  1  write-back data select: 0=ALUOut, 1=MDR.
- output_ALUSrcA  output  1  ALU operand A select: 0=PC, 1=RegA.
- output_ALUSrcB  output  2  ALU operand B select: 0=RegB, 1=constant 1, 2=Imm, 3=reserved.
- output_ALUOp  output  3  ALU function: 0=ADD, 1=SUB, 2=AND, 3=OR.
- output_PCSource  output  2  PC next-value select: 0=ALU result, 1=ALUOut, 2=Imm.
- output_state  output  4  current state code, for debug.
- output_halted  output  1  high in HALT.
- output_illegal  output  1  high in ILLEGAL.
- output_instr_count  output  CNT_W  number of fetches performed.
- output_cycle_count  output  CNT_W  number of cycles run.

Behaviour:
- Opcode map:
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR (register ops)
  - 0x10 ADDI, 0x20 LW, 0x21 SW
  - 0x30 BEQ, 0x31 BNE, 0x40 JUMP, 0x7F HALT
  - Any other opcode is illegal.
- State codes: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_READ=5, MEM_WB=6, MEM_WRITE=7, RTYPE_WB=8, BRANCH=9, JUMP=10, HALT=11, ILLEGAL=12.
- Default output values: all strobes 0, all selects 0. Each state's entry below lists only the deviations from these defaults.
- Outputs are combinational decode of the state register. The one exception is output_PC_PCWrite in BRANCH, which also depends on input_ALU_zero.
- FETCH: IorD=0, IR_write=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0, PCWrite=1. Next state: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=2, ALUOp=ADD, so ALUOut becomes the branch target (incremented PC + Imm). Next state by opcode:
  - register ops -> EXEC_R
  - ADDI -> EXEC_I
  - LW/SW -> MEM_ADDR
  - BEQ/BNE -> BRANCH
  - JUMP -> JUMP
  - HALT -> HALT
  - anything else -> ILLEGAL
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=opcode[1:0]. Next state: RTYPE_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUOp=ADD. Next state: RTYPE_WB.
- RTYPE_WB: reg_write=1, MemToReg=0. Next state: FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=ADD. Next state: MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: IorD=1. Next state: MEM_WB. The MDR captures memory output every cycle.
- MEM_WB: reg_write=1, MemToReg=1. Next state: FETCH.
- MEM_WRITE: IorD=1, mem_write=1. Next state: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCSource=1. PCWrite=input_ALU_zero for BEQ, =!input_ALU_zero for BNE. Next state: FETCH.
- JUMP: PCSource=2, PCWrite=1. Next state: FETCH.
- HALT and ILLEGAL: all strobes 0. Terminal until reset. output_halted / output_illegal high.
- Opcode timing: the opcode is sampled in DECODE and each state after it. The IR is not written outside FETCH, so the opcode is stable.
- Instruction latency: R-type/ADDI 4 cycles, LW 5, SW 4, BEQ/BNE 3, JUMP 3, HALT 2 to entry.
- Counters:
  - instr_count increments by 1 on every FETCH cycle.
  - cycle_count increments on every cycle in which the state is not HALT or ILLEGAL.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset: when RST_N=0 at an edge, the state goes to FETCH and both counters go to 0.
- Reset has priority over every transition, including mid-instruction and in HALT/ILLEGAL.
- While RST_N=0, all write strobes are forced 0 combinationally: PCWrite, IR_write, mem_write, reg_write. The selects show FETCH values, output_state=0, halted=0, illegal=0.

Test Plan:
- Reset, then ADD (0x00) -> states 0,1,2,8,0. reg_write=1 only in cycle 4. instr_count=1, cycle_count=4.
- LW (0x20) -> states 0,1,4,5,6. IorD=1 in MEM_READ. MemToReg=1 with reg_write=1 in MEM_WB. SW (0x21) -> mem_write=1 exactly one cycle, state 7.
- BEQ with zero=1 -> PCWrite=1, PCSource=1 in BRANCH. Same with zero=0 -> PCWrite=0. BNE inverts both results.
- Opcode 0x55 -> ILLEGAL after DECODE, illegal=1, strobes 0, cycle_count frozen. RST_N=0 one cycle -> state 0, counters 0.
- HALT (0x7F) -> halted=1, state 11 held 20 cycles, cycle_count stops. Reset asserted in EXEC_R -> next state FETCH, no reg_write issued.
- CNT_W=4, run 20 FETCH cycles -> instr_count saturates at 15.
